// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse sequencer: enables data reporting, waits for the acknowledge with
// bounded retries, then decodes 3-byte stream packets into X/Y deltas and buttons.
module ps2_mouse_ctrl #(
  parameter logic [7:0] INIT_CMD    = 8'hF4,
  parameter logic [7:0] ACK_BYTE    = 8'hFA,
  parameter int         ACK_TIMEOUT = 5_000_000,
  parameter int         PKT_TIMEOUT = 2_000_000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic       tx_done,
  input  logic [7:0] dout,
  output logic       wr_ps2,
  output logic [7:0] din,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btnm,
  output logic [1:0] ovf,
  output logic       m_done_tick,
  output logic       init_done,
  output logic       init_err
);

  localparam int TMAX = (ACK_TIMEOUT > PKT_TIMEOUT) ? ACK_TIMEOUT : PKT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] PKT_LAST   = TW'(PKT_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_SAT  = TW'(TMAX);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    SEND     = 3'd0,
    WAIT_TX  = 3'd1,
    WAIT_ACK = 3'd2,
    PKT0     = 3'd3,
    PKT1     = 3'd4,
    PKT2     = 3'd5,
    ERR      = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [7:0]    byte1_q, byte1_d;
  logic [8:0]    xm_q, xm_d;
  logic [8:0]    ym_q, ym_d;
  logic [2:0]    btnm_q, btnm_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          wr_ps2_q, wr_ps2_d;
  logic          tick_q, tick_d;
  logic          init_done_q, init_done_d;
  logic          init_err_q, init_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEND;
      timer_q     <= '0;
      retry_q     <= '0;
      byte0_q     <= '0;
      byte1_q     <= '0;
      xm_q        <= '0;
      ym_q        <= '0;
      btnm_q      <= '0;
      ovf_q       <= '0;
      wr_ps2_q    <= 1'b0;
      tick_q      <= 1'b0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      xm_q        <= xm_d;
      ym_q        <= ym_d;
      btnm_q      <= btnm_d;
      ovf_q       <= ovf_d;
      wr_ps2_q    <= wr_ps2_d;
      tick_q      <= tick_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    // Saturating count so a long idle never wraps back into a false expiry.
    timer_d     = (timer_q == TIMER_SAT) ? timer_q : timer_q + 1'b1;
    retry_d     = retry_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    xm_d        = xm_q;
    ym_d        = ym_q;
    btnm_d      = btnm_q;
    ovf_d       = ovf_q;
    wr_ps2_d    = 1'b0;
    tick_d      = 1'b0;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;

    case (state_q)
      SEND: begin
        wr_ps2_d = 1'b1;
        state_d  = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
          timer_d = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_done && (dout == ACK_BYTE)) begin
          init_done_d = 1'b1;
          state_d     = PKT0;
        end else if (timer_q == ACK_LAST) begin
          if (retry_q == RETRY_LAST) begin
            init_err_d = 1'b1;
            state_d    = ERR;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      PKT0: begin
        timer_d = '0;
        if (rx_done && dout[3]) begin
          byte0_d = dout;
          state_d = PKT1;
        end
      end
      PKT1: begin
        if (rx_done) begin
          byte1_d = dout;
          timer_d = '0;
          state_d = PKT2;
        end else if (timer_q == PKT_LAST) begin
          state_d = PKT0;
        end
      end
      PKT2: begin
        if (rx_done) begin
          xm_d    = {byte0_q[4], byte1_q};
          ym_d    = {byte0_q[5], dout};
          btnm_d  = byte0_q[2:0];
          ovf_d   = byte0_q[7:6];
          tick_d  = 1'b1;
          timer_d = '0;
          state_d = PKT0;
        end else if (timer_q == PKT_LAST) begin
          state_d = PKT0;
        end
      end
      ERR: begin
        init_done_d = 1'b0;
        init_err_d  = 1'b1;
      end
      default: state_d = SEND;
    endcase
  end

  assign wr_ps2      = wr_ps2_q;
  assign din         = INIT_CMD;
  assign xm          = xm_q;
  assign ym          = ym_q;
  assign btnm        = btnm_q;
  assign ovf         = ovf_q;
  assign m_done_tick = tick_q;
  assign init_done   = init_done_q;
  assign init_err    = init_err_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: init handshake, packet decode, sync discard,
// packet timeout, retry/error and reset mid-packet.
module tb_ps2_mouse_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] dout;
  logic       wr_ps2;
  logic [7:0] din;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btnm;
  logic [1:0] ovf;
  logic       m_done_tick;
  logic       init_done;
  logic       init_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_cnt = 0;
  logic [22:0] obs_q[$];

  ps2_mouse_ctrl #(
    .INIT_CMD   (8'hF4),
    .ACK_BYTE   (8'hFA),
    .ACK_TIMEOUT(100),
    .PKT_TIMEOUT(50),
    .MAX_RETRY  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_done    (rx_done),
    .tx_done    (tx_done),
    .dout       (dout),
    .wr_ps2     (wr_ps2),
    .din        (din),
    .xm         (xm),
    .ym         (ym),
    .btnm       (btnm),
    .ovf        (ovf),
    .m_done_tick(m_done_tick),
    .init_done  (init_done),
    .init_err   (init_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_ps2) wr_cnt <= wr_cnt + 1;
  end

  // Every tick's packet is captured for later comparison against hand-computed values.
  always @(negedge clk) begin
    if (m_done_tick) obs_q.push_back({xm, ym, btnm, ovf});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_rx(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    dout    = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic wait_wr(input string tag);
    int n;
    n = 0;
    while (!wr_ps2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, wr_ps2}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic init_handshake();
    wait_wr("init_wr");
    check("init_din", {24'd0, din}, 32'hF4);
    pulse_tx();
    pulse_rx(8'hFA);
    check("init_done_after_ack", {31'd0, init_done}, 32'd1);
  endtask

  task automatic expect_one_pkt(input string tag, input logic [22:0] e);
    repeat (2) @(negedge clk);
    check({tag, "_count"}, obs_q.size(), 32'd1);
    if (obs_q.size() > 0) check(tag, {9'd0, obs_q[0]}, {9'd0, e});
    obs_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t_prev;
    reset   = 1'b1;
    rx_done = 1'b0;
    tx_done = 1'b0;
    dout    = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_wr_ps2", {31'd0, wr_ps2}, 32'd0);
    check("rst_xm", {23'd0, xm}, 32'd0);
    check("rst_ym", {23'd0, ym}, 32'd0);
    check("rst_btn_ovf", {27'd0, btnm, ovf}, 32'd0);
    check("rst_tick", {31'd0, m_done_tick}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_init_err", {31'd0, init_err}, 32'd0);

    // 1: init handshake, with a stray non-ack byte that must be ignored
    base  = wr_cnt;
    reset = 1'b0;
    wait_wr("t1_wr");
    check("t1_din", {24'd0, din}, 32'hF4);
    pulse_tx();
    pulse_rx(8'h55);
    check("t1_non_ack_ignored", {31'd0, init_done}, 32'd0);
    pulse_rx(8'hFA);
    check("t1_init_done", {31'd0, init_done}, 32'd1);
    repeat (3) @(negedge clk);
    check("t1_wr_pulses", wr_cnt - base, 32'd1);

    // 2: packet decode
    pulse_rx(8'h19);
    pulse_rx(8'h05);
    pulse_rx(8'hFB);
    check("t2_tick_now", {31'd0, m_done_tick}, 32'd1);
    @(negedge clk);
    check("t2_tick_one_cycle", {31'd0, m_done_tick}, 32'd0);
    expect_one_pkt("t2_pkt", {9'h105, 9'h0FB, 3'b001, 2'b00});

    // 3: sync-bit discard
    pulse_rx(8'h00);
    pulse_rx(8'h08);
    pulse_rx(8'h10);
    pulse_rx(8'h20);
    expect_one_pkt("t3_pkt", {9'h010, 9'h020, 3'b000, 2'b00});

    // 4: inter-byte timeout drops the partial packet
    pulse_rx(8'h09);
    pulse_rx(8'h7F);
    repeat (60) @(negedge clk);
    pulse_rx(8'h08);
    pulse_rx(8'h01);
    pulse_rx(8'h02);
    expect_one_pkt("t4_pkt", {9'h001, 9'h002, 3'b000, 2'b00});

    // 6: reset mid-packet
    pulse_rx(8'h09);
    pulse_rx(8'h01);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_xm", {23'd0, xm}, 32'd0);
    check("t6_rst_ym", {23'd0, ym}, 32'd0);
    check("t6_rst_btn", {29'd0, btnm}, 32'd0);
    check("t6_rst_init_done", {31'd0, init_done}, 32'd0);
    reset = 1'b0;
    init_handshake();
    pulse_rx(8'h08);
    pulse_rx(8'h03);
    pulse_rx(8'h04);
    expect_one_pkt("t6_pkt", {9'h003, 9'h004, 3'b000, 2'b00});

    // 5: retries exhausted, then error until reset
    do_reset();
    base   = wr_cnt;
    t_prev = 0;
    reset  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_wr("t5_wr");
      if (i > 0) check("t5_gap", {31'd0, (cyc - t_prev) >= 100}, 32'd1);
      t_prev = cyc;
      pulse_tx();
    end
    repeat (150) @(negedge clk);
    check("t5_init_err", {31'd0, init_err}, 32'd1);
    check("t5_init_done", {31'd0, init_done}, 32'd0);
    check("t5_wr_pulses", wr_cnt - base, 32'd4);
    do_reset();
    check("t5_rst_init_err", {31'd0, init_err}, 32'd0);
    reset = 1'b0;
    wait_wr("t5_rewr");
    check("t5_no_stray_pkts", obs_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
